// File: rtl/neuron_accum_if.sv
// Product-stream and result-stream bundle for one neuron accumulator.
// The master drives products, bias, clear and downstream ready. The slave is the accumulator.
interface neuron_accum_if #(
  parameter int ACC_W = 32
);
  logic             clear;
  logic [15:0]      prod;
  logic             prod_valid;
  logic             prod_ready;
  logic [15:0]      bias;
  logic [7:0]       out_act;
  logic [ACC_W:0]   out_sum;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output clear, prod, prod_valid, bias, out_ready,
    input  prod_ready, out_act, out_sum, out_valid
  );

  modport slave (
    input  clear, prod, prod_valid, bias, out_ready,
    output prod_ready, out_act, out_sum, out_valid
  );
endinterface

// File: rtl/neuron_accum.sv
// Sums N_INPUTS unsigned products, adds bias, shifts right by SHIFT and
// saturates to an 8-bit activation for the next layer's multiplier.
module neuron_accum #(
  parameter int N_INPUTS = 16,
  parameter int SHIFT    = 8,
  parameter int ACC_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  neuron_accum_if.slave bus
);
  localparam int CNT_W = $clog2(N_INPUTS) + 1;

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W:0]   sum_q, sum_d;
  logic [7:0]       act_q, act_d;
  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;
  logic [ACC_W:0]   fin_sum;

  function automatic logic [7:0] sat_act(input logic [ACC_W:0] s);
    logic [ACC_W:0] sh;
    sh = s >> SHIFT;
    return (sh > (ACC_W+1)'(255)) ? 8'hFF : sh[7:0];
  endfunction

  // Final beat is folded in directly so the result is ready on the accepting edge.
  assign fin_sum = {1'b0, acc_q} + (ACC_W+1)'(bus.prod) + (ACC_W+1)'(bus.bias);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    act_d   = act_q;
    if (bus.clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.prod_valid && rdy_q) begin
            if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
              sum_d   = fin_sum;
              act_d   = sat_act(fin_sum);
              acc_d   = '0;
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              acc_d = acc_q + ACC_W'(bus.prod);
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
    rdy_d = (state_d == ACCUM);
    vld_d = (state_d == DONE);
  end

  // Handshake flags are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      act_q   <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      act_q   <= act_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.prod_ready = rdy_q;
  assign bus.out_valid  = vld_q;
  assign bus.out_sum    = sum_q;
  assign bus.out_act    = act_q;
endmodule

// File: tb/tb_neuron_accum.sv
// Bench for neuron_accum: three instances (SHIFT 4, 16, 0) share one stimulus
// stream and are compared each cycle with a transaction-level model.
module tb_neuron_accum;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        prod_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] prod = '0;
  logic [15:0] bias = '0;

  always #5 clk = ~clk;

  neuron_accum_if #(.ACC_W(32)) if4 ();
  neuron_accum_if #(.ACC_W(32)) if16 ();
  neuron_accum_if #(.ACC_W(32)) if0 ();

  assign if4.clear = clear;   assign if16.clear = clear;   assign if0.clear = clear;
  assign if4.prod = prod;     assign if16.prod = prod;     assign if0.prod = prod;
  assign if4.prod_valid = prod_valid; assign if16.prod_valid = prod_valid; assign if0.prod_valid = prod_valid;
  assign if4.bias = bias;     assign if16.bias = bias;     assign if0.bias = bias;
  assign if4.out_ready = out_ready; assign if16.out_ready = out_ready; assign if0.out_ready = out_ready;

  neuron_accum #(.N_INPUTS(N), .SHIFT(4),  .ACC_W(32)) u4  (.clk(clk), .rst(rst), .bus(if4.slave));
  neuron_accum #(.N_INPUTS(N), .SHIFT(16), .ACC_W(32)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));
  neuron_accum #(.N_INPUTS(N), .SHIFT(0),  .ACC_W(32)) u0  (.clk(clk), .rst(rst), .bus(if0.slave));

  int n_cmp = 0;
  int n_fail = 0;

  // Model: accepted beats of the current neuron, pending-result flag, last result.
  longint q[$];
  bit     m_valid;
  longint m_sum;

  typedef struct {
    longint p[4];
    longint b;
    longint es;
    longint ea4;
    longint ea16;
    longint ea0;
  } vec_t;
  vec_t vt[6];

  function automatic longint sat(longint s, int sh);
    longint v;
    v = s >> sh;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic chk(string name, longint got, longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_sum = 0;
  endtask

  task automatic model_edge();
    longint s;
    if (clear) begin
      q.delete();
      m_valid = 1'b0;
    end else if (!m_valid) begin
      if (prod_valid) begin
        q.push_back(longint'(prod));
        if (q.size() == N) begin
          s = longint'(bias);
          foreach (q[i]) s += q[i];
          m_sum = s;
          q.delete();
          m_valid = 1'b1;
        end
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_one(string tag, logic pr, logic ov, logic [32:0] s, logic [7:0] a, int sh);
    chk({tag, ".prod_ready"}, longint'(pr), longint'(!m_valid));
    chk({tag, ".out_valid"},  longint'(ov), longint'(m_valid));
    chk({tag, ".out_sum"},    longint'(s),  m_sum);
    chk({tag, ".out_act"},    longint'(a),  sat(m_sum, sh));
  endtask

  task automatic check_all();
    check_one("s4",  if4.prod_ready,  if4.out_valid,  if4.out_sum,  if4.out_act,  4);
    check_one("s16", if16.prod_ready, if16.out_valid, if16.out_sum, if16.out_act, 16);
    check_one("s0",  if0.prod_ready,  if0.out_valid,  if0.out_sum,  if0.out_act,  0);
  endtask

  task automatic cyc(bit clr, bit pv, logic [15:0] p, logic [15:0] b, bit ordy);
    clear = clr; prod_valid = pv; prod = p; bias = b; out_ready = ordy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst.out_valid_now", longint'(if4.out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    vt[0] = '{'{100, 200, 300, 400},         24,    1024,   64,  0,   255};
    vt[1] = '{'{65025, 65025, 65025, 65025}, 65535, 325635, 255, 4,   255};
    vt[2] = '{'{16, 16, 16, 16},             0,     64,     4,   0,   64};
    vt[3] = '{'{0, 0, 0, 0},                 0,     0,      0,   0,   0};
    vt[4] = '{'{1000, 2000, 3000, 4000},     5,     10005,  255, 0,   255};
    vt[5] = '{'{10, 20, 30, 40},             3000,  3100,   193, 0,   255};

    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();

    // Table vectors, back-to-back beats with out_ready held high.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N; i++) cyc(0, 1, 16'(vt[v].p[i]), 16'(vt[v].b), 1);
      chk("tbl.valid", longint'(if4.out_valid), 1);
      chk("tbl.sum",   longint'(if4.out_sum), vt[v].es);
      chk("tbl.act4",  longint'(if4.out_act), vt[v].ea4);
      chk("tbl.act16", longint'(if16.out_act), vt[v].ea16);
      chk("tbl.act0",  longint'(if0.out_act), vt[v].ea0);
      cyc(0, 0, 0, 16'(vt[v].b), 1);
      chk("tbl.valid_1cyc", longint'(if4.out_valid), 0);
    end

    // Backpressure: beats offered while DONE are ignored.
    for (int i = 0; i < N; i++) cyc(0, 1, 16'(100 * (i + 1)), 24, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 777, 24, 0);
      chk("bp.prod_ready", longint'(if4.prod_ready), 0);
      chk("bp.sum_hold", longint'(if4.out_sum), 1024);
    end
    cyc(0, 1, 777, 24, 1);
    for (int i = 0; i < N; i++) cyc(0, 1, 16'(i + 1), 10, 1);
    chk("bp.next_sum", longint'(if4.out_sum), 20);
    cyc(0, 0, 0, 10, 1);

    // Gaps between beats.
    for (int i = 0; i < N; i++) begin
      cyc(0, 1, 16'(100 * (i + 1)), 24, 1);
      if (i != N - 1) for (int g = 0; g < 3; g++) cyc(0, 0, 0, 24, 1);
    end
    chk("gap.valid", longint'(if4.out_valid), 1);
    chk("gap.sum", longint'(if4.out_sum), 1024);
    chk("gap.act", longint'(if4.out_act), 64);
    cyc(0, 0, 0, 24, 1);

    // Clear colliding with a valid beat.
    cyc(0, 1, 50, 0, 1);
    cyc(0, 1, 50, 0, 1);
    cyc(1, 1, 50, 0, 1);
    for (int i = 0; i < N; i++) cyc(0, 1, 16, 0, 1);
    chk("clr.sum", longint'(if0.out_sum), 64);
    chk("clr.act", longint'(if0.out_act), 64);
    // Clear colliding with the output handshake.
    cyc(1, 0, 0, 0, 1);
    chk("clr.sum_kept", longint'(if0.out_sum), 64);

    // Async reset mid-accumulation and in DONE.
    cyc(0, 1, 500, 7, 1);
    cyc(0, 1, 600, 7, 1);
    async_reset();
    for (int i = 0; i < N; i++) cyc(0, 1, 16'(100 * (i + 1)), 24, 0);
    cyc(0, 0, 0, 24, 0);
    async_reset();
    for (int i = 0; i < N; i++) cyc(0, 1, 16'(100 * (i + 1)), 24, 1);
    chk("rst.next_sum", longint'(if4.out_sum), 1024);
    cyc(0, 0, 0, 24, 1);

    // Randomized traffic; bias changes only between neurons.
    begin
      logic [15:0] rb;
      logic [15:0] rp;
      rb = 16'($urandom);
      for (int c = 0; c < 600; c++) begin
        if (q.size() == 0 && !m_valid && ($urandom % 3 == 0)) rb = 16'($urandom);
        rp = ($urandom % 5 == 0) ? 16'd65025 : 16'($urandom);
        cyc(($urandom % 40) == 0, ($urandom % 4) != 0, rp, rb, ($urandom % 3) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/neuron_accum.md
# neuron_accum

Accumulation and activation stage that sits directly downstream of the 8x8 unsigned multiplier in each neural-network tile. It consumes a stream of 16-bit products with a valid/ready handshake and sums N_INPUTS of them. It then adds a per-neuron bias, scales the sum by a right shift, and saturates the result to an 8-bit activation. That 8-bit width is the operand width the next layer's multiplier takes.

## Interface
- N_INPUTS, 16: products summed per neuron output; legal range is 2 to 1024.
- SHIFT, 8: right-shift applied to (accumulator + bias) before saturation; legal range is 0 to ACC_W.
- ACC_W, 32: accumulator width; must be at least 16 + clog2(N_INPUTS), which guarantees the accumulator never overflows.
- clk  input  1  the only clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; discards any partial sum or pending result.
- prod  input  16  unsigned product from the multiplier.
- prod_valid  input  1  `prod` is valid this cycle.
- prod_ready  output  1  block accepts `prod` this cycle.
- bias  input  16  unsigned bias; must be held stable from the first accepted product until the output handshake.
- out_act  output  8  saturated activation.
- out_sum  output  ACC_W+1  unscaled accumulator + bias, for debug and verification.
- out_valid  output  1  `out_act` and `out_sum` are valid.
- out_ready  input  1  downstream accepts the result.

## Operation
- States:
  - ACCUM: `prod_ready`=1, `out_valid`=0.
  - DONE: `prod_ready`=0, `out_valid`=1.
- Reset (async) drives: state=ACCUM, acc=0, count=0, `out_act`=0, `out_sum`=0, `out_valid`=0. `prod_ready` is 1 immediately after reset deasserts.
- Accept: a product is accepted when `prod_valid` and `prod_ready` are both high at a clock edge.
  - On acceptance in ACCUM: acc += zero-extended `prod`, count += 1.
- Finalize: when the accepted product brings count to N_INPUTS, on that same edge:
  - sum = acc + prod + bias, computed at ACC_W+1 bits.
  - `out_sum` = sum.
  - `out_act` = 255 if (sum >> SHIFT) > 255, otherwise (sum >> SHIFT)[7:0].
  - acc=0, count=0, state goes to DONE.
- DONE: `out_act` and `out_sum` are held constant while `out_ready`=0. `prod_valid` is ignored.
- Output handshake: `out_valid` and `out_ready` both high at an edge moves state to ACCUM and clears `out_valid`. `out_act` and `out_sum` keep their last values.
- Gaps: cycles in ACCUM with `prod_valid`=0 change nothing. Beats need not be contiguous.
- `clear`=1 at an edge forces acc=0, count=0, state=ACCUM, `out_valid`=0.
  - `clear` has priority over a simultaneous product acceptance, which is discarded.
  - `clear` has priority over a simultaneous output handshake.
  - `out_act` and `out_sum` are unchanged.
- Arithmetic is entirely unsigned; there is no wrap-around anywhere.
- count runs from 0 to N_INPUTS-1 and is sized clog2(N_INPUTS)+1 bits.

## Timing
- `prod_ready` is a registered function of state only. It has no combinational path from `prod_valid`.
- Latency: `out_valid` rises in the cycle after the edge that accepts the N_INPUTS-th product.
- Throughput: the minimum per neuron is N_INPUTS accept cycles plus 1 DONE cycle (with `out_ready` held at 1).
  - The first product of the next neuron is accepted no earlier than the edge after the output handshake.
- `out_valid`, `out_act`, `out_sum` and `prod_ready` are all driven directly from flops.
- Asserting reset at any point, including mid-accumulation or in DONE, takes effect without waiting for a clock edge and discards any partial or pending result.

## Test plan
- Basic: N_INPUTS=4, SHIFT=4, bias=24, products 100, 200, 300, 400 on consecutive cycles, `out_ready`=1 -> `out_sum`=1024 and `out_act`=64 one cycle after the 4th beat; `out_valid` is high for exactly 1 cycle.
- Saturation: N_INPUTS=4, SHIFT=4, bias=65535, four products of 65025 -> `out_sum`=325635 and `out_act`=255; with SHIFT=16 instead -> `out_act`=4.
- Backpressure: complete a neuron with `out_ready`=0 for 5 cycles while `prod_valid`=1 -> `prod_ready`=0 and outputs stable for all 5 cycles; when `out_ready` rises, the next neuron starts the following cycle, and the ignored beats are not counted.
- Gaps: the Basic products with `prod_valid` low for 3 cycles between each beat -> same result (1024/64); `out_valid` rises one cycle after the 4th accepted beat.
- Clear collision: after 2 beats, assert `clear` together with a valid beat -> the beat is discarded; 4 fresh beats of 16 with bias=0 and SHIFT=0 -> `out_sum`=64, `out_act`=64.
- Async reset: assert `rst` between clock edges mid-accumulation and while in DONE -> outputs go to their reset values immediately; the next full neuron's result is correct.
